// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared types and encodings for the multi-cycle RV64 control FSM.
package riscv_ctrl_pkg;

    localparam int unsigned TMO_W = 8;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        BRANCH,
        TRAP
    } state_e;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // ALU operand selects
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;

    // Opcode / funct encodings
    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_SD = 7'b0100011;
    localparam logic [6:0] OPC_BR = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_DW  = 3'b011;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LD,
        CLS_SD,
        CLS_BEQ,
        CLS_BNE,
        CLS_ILL
    } op_class_e;

    // Control strobes driven towards the datapath and memories
    typedef struct packed {
        logic       imem_req;
        logic       dmem_read;
        logic       dmem_write;
        logic [3:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic       mem_to_reg;
        logic       instr_done;
        logic       trap;
    } ctrl_t;

    // Coarse instruction class used for DECODE dispatch and later phases
    function automatic op_class_e classify(input logic [6:0] opcode, input logic [2:0] funct3);
        op_class_e cls;
        cls = CLS_ILL;
        case (opcode)
            OPC_R:   cls = CLS_R;
            OPC_I:   cls = CLS_I;
            OPC_LD:  if (funct3 == F3_DW) cls = CLS_LD;
            OPC_SD:  if (funct3 == F3_DW) cls = CLS_SD;
            OPC_BR: begin
                if (funct3 == F3_BEQ)      cls = CLS_BEQ;
                else if (funct3 == F3_BNE) cls = CLS_BNE;
            end
            default: cls = CLS_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: opcode/funct3/funct7 -> ALU operation for the EXEC phase, plus legality.
module alu_op_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op_c,
    output logic       legal_c
);

    // Only add/sub/and/or (register and immediate forms) plus ld/sd address add are supported
    always_comb begin
        alu_op_c = ALU_ADD;
        legal_c  = 1'b0;
        case (opcode)
            OPC_R: begin
                case (funct3)
                    F3_ADD: begin
                        if (funct7 == F7_BASE) begin
                            alu_op_c = ALU_ADD;
                            legal_c  = 1'b1;
                        end else if (funct7 == F7_ALT) begin
                            alu_op_c = ALU_SUB;
                            legal_c  = 1'b1;
                        end
                    end
                    F3_AND: begin
                        alu_op_c = ALU_AND;
                        legal_c  = (funct7 == F7_BASE);
                    end
                    F3_OR: begin
                        alu_op_c = ALU_OR;
                        legal_c  = (funct7 == F7_BASE);
                    end
                    default: legal_c = 1'b0;
                endcase
            end
            OPC_I: begin
                // funct7 bits are immediate bits here and do not select the operation
                case (funct3)
                    F3_ADD: begin
                        alu_op_c = ALU_ADD;
                        legal_c  = 1'b1;
                    end
                    F3_AND: begin
                        alu_op_c = ALU_AND;
                        legal_c  = 1'b1;
                    end
                    F3_OR: begin
                        alu_op_c = ALU_OR;
                        legal_c  = 1'b1;
                    end
                    default: legal_c = 1'b0;
                endcase
            end
            OPC_LD, OPC_SD: begin
                alu_op_c = ALU_ADD;
                legal_c  = (funct3 == F3_DW);
            end
            default: legal_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: multi-cycle main control FSM (FETCH/DECODE/EXEC/MEM/WB/BRANCH/TRAP).
// Optional feature: define RISCV_CTRL_BNE_EN to accept bne; otherwise bne traps.
// A memory wait times out in the cycle the wait counter equals MEM_TIMEOUT, i.e. after
// MEM_TIMEOUT unanswered request cycles; the request is dropped in that cycle.
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Instruction,
    input  logic        Zero,
    input  logic        IMemReady,
    input  logic        DMemReady,
    output logic        IMemReq,
    output logic        DMemRead,
    output logic        DMemWrite,
    output logic [3:0]  ALUOp,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        InstrDone,
    output logic        Trap
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);
`ifdef RISCV_CTRL_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    state_e           state;
    state_e           state_next;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             waiting;
    op_class_e        op_class;
    logic [3:0]       exec_alu_op;
    logic             exec_legal;
    logic             is_ld;
    ctrl_t            ctrl;
    ctrl_t            ctrl_out;
    logic [14:0]      unused_instr_bits;

    // Register/immediate fields are consumed by the datapath, not by control
    assign unused_instr_bits = {Instruction[24:15], Instruction[11:7]};

    assign op_class = classify(Instruction[6:0], Instruction[14:12]);
    assign is_ld    = (op_class == CLS_LD);
    assign tmo_hit  = (tmo_cnt == TMO_LIMIT);
    assign waiting  = ((state == FETCH) && !IMemReady) || ((state == MEM) && !DMemReady);

    alu_op_decode u_alu_op_decode (
        .opcode   (Instruction[6:0]),
        .funct3   (Instruction[14:12]),
        .funct7   (Instruction[31:25]),
        .alu_op_c (exec_alu_op),
        .legal_c  (exec_legal)
    );

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) state <= FETCH;
        else       state <= state_next;
    end

    // Memory wait counter: restarts on every entry into FETCH or MEM
    always_ff @(posedge Clock) begin
        if (Reset) begin
            tmo_cnt <= '0;
        end else if ((state_next != state) && ((state_next == FETCH) || (state_next == MEM))) begin
            tmo_cnt <= '0;
        end else if (waiting) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Next-state and strobe decode from state, handshakes and Zero
    always_comb begin
        ctrl       = '0;
        state_next = state;
        case (state)
            FETCH: begin
                if (tmo_hit) begin
                    state_next = TRAP;
                end else begin
                    ctrl.imem_req = 1'b1;
                    if (IMemReady) begin
                        ctrl.ir_write  = 1'b1;
                        ctrl.pc_write  = 1'b1;
                        ctrl.pc_src    = 1'b0;
                        ctrl.alu_src_a = SRCA_PC;
                        ctrl.alu_src_b = SRCB_FOUR;
                        ctrl.alu_op    = ALU_ADD;
                        state_next     = DECODE;
                    end
                end
            end
            DECODE: begin
                // Branch target is formed here into ALUOut
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                case (op_class)
                    CLS_R, CLS_I, CLS_LD, CLS_SD: state_next = EXEC;
                    CLS_BEQ:                      state_next = BRANCH;
                    CLS_BNE:                      state_next = BNE_EN ? BRANCH : TRAP;
                    default:                      state_next = TRAP;
                endcase
            end
            EXEC: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = (op_class == CLS_R) ? SRCB_RS2 : SRCB_IMM;
                ctrl.alu_op    = exec_alu_op;
                if (!exec_legal)                                    state_next = TRAP;
                else if ((op_class == CLS_LD) || (op_class == CLS_SD)) state_next = MEM;
                else                                                state_next = WB;
            end
            MEM: begin
                if (tmo_hit) begin
                    state_next = TRAP;
                end else begin
                    ctrl.dmem_read  = is_ld;
                    ctrl.dmem_write = !is_ld;
                    if (DMemReady) begin
                        if (is_ld) begin
                            state_next = WB;
                        end else begin
                            ctrl.instr_done = 1'b1;
                            state_next      = FETCH;
                        end
                    end
                end
            end
            WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = is_ld;
                ctrl.instr_done = 1'b1;
                state_next      = FETCH;
            end
            BRANCH: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALU_SUB;
                ctrl.pc_src     = 1'b1;
                ctrl.pc_write   = (op_class == CLS_BNE) ? !Zero : Zero;
                ctrl.instr_done = 1'b1;
                state_next      = FETCH;
            end
            TRAP: begin
                ctrl.trap = 1'b1;
            end
            default: begin
                state_next = TRAP;
            end
        endcase
    end

    // Everything is silenced while Reset is high, including a request mid-MEM
    assign ctrl_out  = Reset ? '0 : ctrl;

    assign IMemReq   = ctrl_out.imem_req;
    assign DMemRead  = ctrl_out.dmem_read;
    assign DMemWrite = ctrl_out.dmem_write;
    assign ALUOp     = ctrl_out.alu_op;
    assign ALUSrcA   = ctrl_out.alu_src_a;
    assign ALUSrcB   = ctrl_out.alu_src_b;
    assign IRWrite   = ctrl_out.ir_write;
    assign PCWrite   = ctrl_out.pc_write;
    assign PCSrc     = ctrl_out.pc_src;
    assign RegWrite  = ctrl_out.reg_write;
    assign MemToReg  = ctrl_out.mem_to_reg;
    assign InstrDone = ctrl_out.instr_done;
    assign Trap      = ctrl_out.trap;

endmodule
